// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator with pixel clock-enable
// Outputs are registered from the next x/y so they stay aligned with out_rows/out_lines.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int FC_W     = 16
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic            run,
  output logic            pix_ce,
  output logic [CW-1:0]   out_rows,
  output logic [CW-1:0]   out_lines,
  output logic            write_enable,
  output logic            out_hsync,
  output logic            out_vsync,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_LO    = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_HI    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_LO    = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_HI    = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0]   r_div;
  logic [CW-1:0]   r_x;
  logic [CW-1:0]   r_y;
  logic            r_pix_ce;
  logic            r_we;
  logic            r_hsync;
  logic            r_vsync;
  logic            r_line_start;
  logic            r_frame_start;
  logic [FC_W-1:0] r_fc;

  logic            w_tick;
  logic            w_x_wrap;
  logic [CW-1:0]   w_x_nxt;
  logic [CW-1:0]   w_y_nxt;
  logic            w_hs_act;
  logic            w_vs_act;
  logic            w_we;
  logic            w_ls;
  logic            w_fs;

  assign w_tick   = run && (r_div == DIV_LAST);
  assign w_x_wrap = (r_x == H_LAST);
  assign w_x_nxt  = w_tick ? (w_x_wrap ? '0 : r_x + 1'b1) : r_x;
  assign w_y_nxt  = (w_tick && w_x_wrap) ? ((r_y == V_LAST) ? '0 : r_y + 1'b1) : r_y;

  // Decode from the post-edge position so every output lines up with the counters.
  assign w_hs_act = (w_x_nxt >= HS_LO) && (w_x_nxt < HS_HI);
  assign w_vs_act = (w_y_nxt >= VS_LO) && (w_y_nxt < VS_HI);
  assign w_we     = (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
  assign w_ls     = w_tick && (w_x_nxt == '0);
  assign w_fs     = w_ls && (w_y_nxt == '0);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_x           <= H_LAST;
      r_y           <= V_LAST;
      r_pix_ce      <= 1'b0;
      r_we          <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_fc          <= '0;
    end else if (!run) begin
      // Park at the restart point so the next tick lands on (0,0); frame_count is kept.
      r_div         <= '0;
      r_x           <= H_LAST;
      r_y           <= V_LAST;
      r_pix_ce      <= 1'b0;
      r_we          <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_tick ? '0 : r_div + 1'b1;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_pix_ce      <= w_tick;
      r_we          <= w_we;
      r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
      r_line_start  <= w_ls;
      r_frame_start <= w_fs;
      if (w_fs) begin
        r_fc <= r_fc + 1'b1;
      end
    end
  end

  assign pix_ce       = r_pix_ce;
  assign out_rows     = r_x;
  assign out_lines    = r_y;
  assign write_enable = r_we;
  assign out_hsync    = r_hsync;
  assign out_vsync    = r_vsync;
  assign line_start   = r_line_start;
  assign frame_start  = r_frame_start;
  assign frame_count  = r_fc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen over three configurations
module tb_vga_timing_gen;

  typedef struct packed {
    logic        ce;
    logic [15:0] x;
    logic [15:0] y;
    logic        we;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    int   id;
    obs_t o;
  } sb_t;

  localparam int C_DIV [3] = '{2, 1, 3};
  localparam int C_HA  [3] = '{640, 4, 5};
  localparam int C_HF  [3] = '{16, 1, 2};
  localparam int C_HS  [3] = '{96, 1, 3};
  localparam int C_HB  [3] = '{48, 1, 2};
  localparam int C_VA  [3] = '{480, 3, 4};
  localparam int C_VF  [3] = '{10, 1, 1};
  localparam int C_VS  [3] = '{2, 1, 2};
  localparam int C_VB  [3] = '{33, 1, 1};
  localparam int C_HP  [3] = '{0, 1, 0};
  localparam int C_VP  [3] = '{0, 1, 1};
  localparam int C_FCW [3] = '{16, 2, 3};

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n = 1'b0;
  logic [2:0] run_v = 3'b000;

  logic a_ce, a_we, a_hs, a_vs, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [15:0] a_fc;
  logic b_ce, b_we, b_hs, b_vs, b_ls, b_fs;
  logic [3:0] b_x, b_y;
  logic [1:0] b_fc;
  logic c_ce, c_we, c_hs, c_vs, c_ls, c_fs;
  logic [3:0] c_x, c_y;
  logic [2:0] c_fc;

  int n_tests = 0;
  int n_fail = 0;
  sb_t sbq[$];
  longint k_run [3] = '{0, 0, 0};
  longint fc_base [3] = '{0, 0, 0};

  vga_timing_gen u_a (
    .clk_in(clk), .rst_n(rst_n), .run(run_v[0]), .pix_ce(a_ce), .out_rows(a_x), .out_lines(a_y),
    .write_enable(a_we), .out_hsync(a_hs), .out_vsync(a_vs), .line_start(a_ls), .frame_start(a_fs),
    .frame_count(a_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .FC_W(2)
  ) u_b (
    .clk_in(clk), .rst_n(rst_n), .run(run_v[1]), .pix_ce(b_ce), .out_rows(b_x), .out_lines(b_y),
    .write_enable(b_we), .out_hsync(b_hs), .out_vsync(b_vs), .line_start(b_ls), .frame_start(b_fs),
    .frame_count(b_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(5), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2),
    .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b1), .CW(4), .FC_W(3)
  ) u_c (
    .clk_in(clk), .rst_n(rst_n), .run(run_v[2]), .pix_ce(c_ce), .out_rows(c_x), .out_lines(c_y),
    .write_enable(c_we), .out_hsync(c_hs), .out_vsync(c_vs), .line_start(c_ls), .frame_start(c_fs),
    .frame_count(c_fc)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  function automatic longint frames_of(input int id, input longint k);
    longint n, ht, vt;
    n  = k / C_DIV[id];
    ht = C_HA[id] + C_HF[id] + C_HS[id] + C_HB[id];
    vt = C_VA[id] + C_VF[id] + C_VS[id] + C_VB[id];
    return (n == 0) ? 0 : (n - 1) / (ht * vt) + 1;
  endfunction

  // Pixel n (1-based) since run rose sits at raster position n-1 in row-major order.
  function automatic obs_t model(input int id, input longint k, input longint fcb);
    obs_t o;
    longint n, q, ht, vt, x, y, hs0, vs0;
    ht  = C_HA[id] + C_HF[id] + C_HS[id] + C_HB[id];
    vt  = C_VA[id] + C_VF[id] + C_VS[id] + C_VB[id];
    hs0 = C_HA[id] + C_HF[id];
    vs0 = C_VA[id] + C_VF[id];
    n   = k / C_DIV[id];
    o.fc = 16'((fcb + frames_of(id, k)) % (64'd1 << C_FCW[id]));
    if (n == 0) begin
      o.ce = 1'b0; o.x = 16'(ht - 1); o.y = 16'(vt - 1); o.we = 1'b0;
      o.hs = !C_HP[id][0]; o.vs = !C_VP[id][0]; o.ls = 1'b0; o.fs = 1'b0;
    end else begin
      q = n - 1;
      x = q % ht;
      y = (q / ht) % vt;
      o.ce = (k % C_DIV[id]) == 0;
      o.x  = 16'(x);
      o.y  = 16'(y);
      o.we = (x < C_HA[id]) && (y < C_VA[id]);
      o.hs = (x >= hs0 && x < hs0 + C_HS[id]) ? C_HP[id][0] : !C_HP[id][0];
      o.vs = (y >= vs0 && y < vs0 + C_VS[id]) ? C_VP[id][0] : !C_VP[id][0];
      o.ls = o.ce && (x == 0);
      o.fs = o.ls && (y == 0);
    end
    return o;
  endfunction

  function automatic obs_t get_act(input int id);
    obs_t o;
    case (id)
      0: o = '{a_ce, 16'(a_x), 16'(a_y), a_we, a_hs, a_vs, a_ls, a_fs, 16'(a_fc)};
      1: o = '{b_ce, 16'(b_x), 16'(b_y), b_we, b_hs, b_vs, b_ls, b_fs, 16'(b_fc)};
      default: o = '{c_ce, 16'(c_x), 16'(c_y), c_we, c_hs, c_vs, c_ls, c_fs, 16'(c_fc)};
    endcase
    return o;
  endfunction

  always @(posedge clk) begin
    for (int id = 0; id < 3; id++) begin
      sb_t e;
      if (!rst_n) begin
        k_run[id] = 0;
        fc_base[id] = 0;
      end else if (run_v[id]) begin
        k_run[id] = k_run[id] + 1;
      end else begin
        fc_base[id] = fc_base[id] + frames_of(id, k_run[id]);
        k_run[id] = 0;
      end
      e.id = id;
      e.o = model(id, k_run[id], fc_base[id]);
      sbq.push_back(e);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        sb_t e;
        obs_t a;
        e = sbq.pop_front();
        a = get_act(e.id);
        n_tests++;
        if (a != e.o) begin
          n_fail++;
          $display("FAIL sb_dut%0d t=%0t got ce=%0d x=%0d y=%0d we=%0d hs=%0d vs=%0d ls=%0d fs=%0d fc=%0d expected ce=%0d x=%0d y=%0d we=%0d hs=%0d vs=%0d ls=%0d fs=%0d fc=%0d",
                   e.id, $time, a.ce, a.x, a.y, a.we, a.hs, a.vs, a.ls, a.fs, a.fc,
                   e.o.ce, e.o.x, e.o.y, e.o.we, e.o.hs, e.o.vs, e.o.ls, e.o.fs, e.o.fc);
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    int cyc, hs_cnt, hs_min, hs_max, n_ls, n_bf, wait_n;
    longint ls_cyc [2];
    int b_fc_seen [4];
    int b_cyc [4];
    bit done, fs0_ok, fs0_seen, got;
    cyc = 0; hs_cnt = 0; hs_min = 9999; hs_max = -1; n_ls = 0; n_bf = 0;
    done = 0; fs0_ok = 0; fs0_seen = 0;

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_v = 3'b111;

    // Phase 1: A runs until (300,10); B/C get random run drops.
    for (int i = 0; i < 20000 && !done; i++) begin
      @(posedge clk);
      #2;
      cyc++;
      if (a_y == 10'd1 && !a_hs) begin
        hs_cnt++;
        if (int'(a_x) < hs_min) hs_min = int'(a_x);
        if (int'(a_x) > hs_max) hs_max = int'(a_x);
      end
      if (a_ls && n_ls < 2) begin
        ls_cyc[n_ls] = cyc;
        n_ls++;
      end
      if (a_fs && !fs0_seen) begin
        fs0_seen = 1;
        fs0_ok = (a_x == 10'd0) && (a_y == 10'd0);
      end
      if (b_fs && n_bf < 4 && i < 300) begin
        b_fc_seen[n_bf] = int'(b_fc);
        b_cyc[n_bf] = cyc;
        n_bf++;
      end
      if (i >= 300) run_v[1] = ($urandom_range(0, 99) != 0);
      run_v[2] = ($urandom_range(0, 29) != 0);
      if (a_x == 10'd300 && a_y == 10'd10) begin
        run_v[0] = 1'b0;
        done = 1;
      end
    end
    chk("reach_300_10", done, 1);
    chk("a_hsync_clk_count", hs_cnt, 192);
    chk("a_hsync_first_x", hs_min, 656);
    chk("a_hsync_last_x", hs_max, 751);
    chk("a_line_period", (n_ls == 2) ? ls_cyc[1] - ls_cyc[0] : -1, 1600);
    chk("a_first_frame_at_origin", fs0_ok, 1);
    chk("b_frames_seen", n_bf, 4);
    chk("b_fc_1", b_fc_seen[0], 1);
    chk("b_fc_2", b_fc_seen[1], 2);
    chk("b_fc_3", b_fc_seen[2], 3);
    chk("b_fc_wrap", b_fc_seen[3], 0);
    chk("b_frame_period", b_cyc[1] - b_cyc[0], 42);

    @(posedge clk);
    #2;
    chk("a_drop_x", a_x, 799);
    chk("a_drop_y", a_y, 524);
    chk("a_drop_hsync", a_hs, 1);
    chk("a_drop_vsync", a_vs, 1);
    chk("a_drop_fc_hold", a_fc, 1);

    repeat (5) @(posedge clk);
    #2;
    run_v[0] = 1'b1;
    wait_n = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk);
      #2;
      wait_n++;
      if (a_fs) got = 1;
    end
    chk("a_rerun_frame_latency", got ? wait_n : -1, 2);

    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk);
      #2;
      if (!a_hs) got = 1;
    end
    chk("a_reach_hsync", got, 1);

    // Stop the clock low, then reset asynchronously while inside the sync pulse.
    @(negedge clk);
    #1;
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_x", a_x, 799);
    chk("async_y", a_y, 524);
    chk("async_hsync", a_hs, 1);
    chk("async_vsync", a_vs, 1);
    chk("async_pix_ce", a_ce, 0);
    chk("async_we", a_we, 0);
    chk("async_strobes", {a_ls, a_fs}, 0);
    chk("async_fc", a_fc, 0);
    #20;
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_v = 3'b111;

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      run_v[0] = ($urandom_range(0, 199) != 0);
      run_v[1] = ($urandom_range(0, 49) != 0);
      run_v[2] = ($urandom_range(0, 19) != 0);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
